// File: rtl/grf_wb_writer.sv
//------------------------------------------------------------------------------
// Module   : grf_wb_writer
// Purpose  : W-stage write-back: 32x32 GPR file, commit trace FIFO and
//            retire counter. Optional macro GRF_BYPASS_EN adds W->D read bypass.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module grf_wb_writer #(
  parameter int TRACE_DEPTH = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite_W,
  input  logic [4:0]       A3_W,
  input  logic [31:0]      WD_W,
  input  logic [31:0]      PC_W,
  input  logic [31:0]      Instr_W,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [31:0]      trc_pc,
  output logic [4:0]       trc_addr,
  output logic [31:0]      trc_data,
  output logic             trc_ovf,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int                 c_PTR_W   = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(TRACE_DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [CNT_W-1:0]   c_RET_ONE = CNT_W'(1);

  logic [31:0]        r_gpr [0:31];
  logic [31:0]        r_pc_mem   [0:TRACE_DEPTH-1];
  logic [4:0]         r_addr_mem [0:TRACE_DEPTH-1];
  logic [31:0]        r_data_mem [0:TRACE_DEPTH-1];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_retire_cnt;

  logic w_commit;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_commit  = RegWrite_W && (A3_W != 5'd0);
  assign w_full    = (r_count == c_FULL);
  assign trc_valid = (r_count != '0);
  assign w_pop     = trc_valid && trc_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push    = w_commit && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_commit) begin
      r_gpr[A3_W] <= WD_W;
    end
  end

  always_comb begin
    RD1 = (A1 == 5'd0) ? 32'd0 : r_gpr[A1];
    RD2 = (A2 == 5'd0) ? 32'd0 : r_gpr[A2];
`ifdef GRF_BYPASS_EN
    if (w_commit && (A1 == A3_W)) RD1 = WD_W;
    if (w_commit && (A2 == A3_W)) RD2 = WD_W;
`endif
  end

  // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= PC_W;
      r_addr_mem[r_wr_ptr] <= A3_W;
      r_data_mem[r_wr_ptr] <= WD_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_commit && !w_push) r_ovf <= 1'b1;
      if (Instr_W != 32'd0) r_retire_cnt <= r_retire_cnt + c_RET_ONE;
    end
  end

  assign trc_pc     = trc_valid ? r_pc_mem[r_rd_ptr]   : 32'd0;
  assign trc_addr   = trc_valid ? r_addr_mem[r_rd_ptr] : 5'd0;
  assign trc_data   = trc_valid ? r_data_mem[r_rd_ptr] : 32'd0;
  assign trc_ovf    = r_ovf;
  assign retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_grf_wb_writer.sv
//------------------------------------------------------------------------------
// Module   : tb_grf_wb_writer
// Purpose  : Scoreboard bench for grf_wb_writer (default TRACE_DEPTH=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_grf_wb_writer;

  logic        clk;
  logic        reset;
  logic        RegWrite_W;
  logic [4:0]  A3_W;
  logic [31:0] WD_W;
  logic [31:0] PC_W;
  logic [31:0] Instr_W;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_pc;
  logic [4:0]  trc_addr;
  logic [31:0] trc_data;
  logic        trc_ovf;
  logic [31:0] retire_cnt;

  int checks   = 0;
  int failures = 0;

  logic [68:0] exp_q [$];

  grf_wb_writer dut (
    .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .A3_W(A3_W), .WD_W(WD_W),
    .PC_W(PC_W), .Instr_W(Instr_W), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_pc(trc_pc),
    .trc_addr(trc_addr), .trc_data(trc_data), .trc_ovf(trc_ovf),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Trace monitor: every accepted handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (reset && trc_valid && trc_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL trace_unexpected: got pc=0x%08h addr=%0d data=0x%08h expected none",
                 trc_pc, trc_addr, trc_data);
      end else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        if ({trc_pc, trc_addr, trc_data} !== e) begin
          failures++;
          $display("FAIL trace_entry: got pc=0x%08h addr=%0d data=0x%08h expected pc=0x%08h addr=%0d data=0x%08h",
                   trc_pc, trc_addr, trc_data, e[68:37], e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [4:0] a3, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [31:0] instr);
    RegWrite_W = rw;
    A3_W       = a3;
    WD_W       = wd;
    PC_W       = pc;
    Instr_W    = instr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic commit(input logic [4:0] a3, input logic [31:0] wd,
                        input logic [31:0] pc, input bit expect_push);
    drive(1'b1, a3, wd, pc, 32'h0000_0013);
    if (expect_push) exp_q.push_back({pc, a3, wd});
  endtask

  initial begin
    reset     = 1'b0;
    trc_ready = 1'b0;
    A1        = 5'd5;
    A2        = 5'd31;
    idle();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("reset_rd1", RD1, 32'd0);
    chk("reset_rd2", RD2, 32'd0);
    chk("reset_valid", {31'd0, trc_valid}, 32'd0);
    chk("reset_retire", retire_cnt, 32'd0);
    chk("reset_trc_pc", trc_pc, 32'd0);
    chk("reset_ovf", {31'd0, trc_ovf}, 32'd0);

    // Write/read of r8
    step();
    A1 = 5'd8;
    A2 = 5'd8;
    commit(5'd8, 32'h1234_5678, 32'h0000_1000, 1'b1);
    #1;
`ifdef GRF_BYPASS_EN
    chk("same_cycle_rd1", RD1, 32'h1234_5678);
    chk("same_cycle_rd2", RD2, 32'h1234_5678);
`else
    chk("same_cycle_rd1", RD1, 32'd0);
    chk("same_cycle_rd2", RD2, 32'd0);
`endif
    step();
    idle();
    #1;
    chk("after_edge_rd1", RD1, 32'h1234_5678);
    chk("after_edge_rd2", RD2, 32'h1234_5678);
    chk("retire_1", retire_cnt, 32'd1);
    chk("valid_after_push", {31'd0, trc_valid}, 32'd1);
    trc_ready = 1'b1;
    step();
    trc_ready = 1'b0;
    chk("valid_after_drain", {31'd0, trc_valid}, 32'd0);

    // $zero protection
    A1 = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_2000, 32'h0000_0013);
    #1;
    chk("zero_rd1_same", RD1, 32'd0);
    step();
    idle();
    #1;
    chk("zero_rd1_after", RD1, 32'd0);
    chk("zero_no_push", {31'd0, trc_valid}, 32'd0);
    chk("retire_2", retire_cnt, 32'd2);

    // Ordering and handshake, consumer stalled first
    commit(5'd1, 32'h11, 32'h3000, 1'b1);
    step();
    chk("valid_next_cycle", {31'd0, trc_valid}, 32'd1);
    commit(5'd2, 32'h22, 32'h3004, 1'b1);
    step();
    commit(5'd3, 32'h33, 32'h3008, 1'b1);
    step();
    idle();
    #1;
    chk("head_pc", trc_pc, 32'h3000);
    chk("head_addr", {27'd0, trc_addr}, 32'd1);
    chk("head_data", trc_data, 32'h11);
    A1 = 5'd2;
    A2 = 5'd3;
    #1;
    chk("rd_r2", RD1, 32'h22);
    chk("rd_r3", RD2, 32'h33);
    trc_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    trc_ready = 1'b0;
    chk("valid_after_3pops", {31'd0, trc_valid}, 32'd0);
    chk("queue_empty_3", exp_q.size(), 32'd0);

    // Overflow: fifth commit dropped
    for (int i = 0; i < 5; i++) begin
      commit(5'(4 + i), 32'hA0 + 32'(i), 32'h4000 + 32'(4 * i), i < 4);
      step();
    end
    idle();
    #1;
    chk("ovf_set", {31'd0, trc_ovf}, 32'd1);
    chk("retire_10", retire_cnt, 32'd10);
    trc_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    trc_ready = 1'b0;
    chk("valid_after_ovf_drain", {31'd0, trc_valid}, 32'd0);
    chk("queue_empty_ovf", exp_q.size(), 32'd0);

    // Clear sticky flag, then full FIFO with simultaneous pop
    reset = 1'b0;
    exp_q.delete();
    step();
    reset = 1'b1;
    #1;
    chk("ovf_cleared", {31'd0, trc_ovf}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      commit(5'(9 + i), 32'hB0 + 32'(i), 32'h5000 + 32'(4 * i), 1'b1);
      if (i == 4) trc_ready = 1'b1;
      step();
    end
    idle();
    #1;
    chk("no_ovf_with_pop", {31'd0, trc_ovf}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    trc_ready = 1'b0;
    chk("valid_after_full_pop", {31'd0, trc_valid}, 32'd0);
    chk("queue_empty_full_pop", exp_q.size(), 32'd0);
    chk("retire_5", retire_cnt, 32'd5);

    // Asynchronous reset mid-operation
    commit(5'd20, 32'hC0, 32'h6000, 1'b0);
    step();
    commit(5'd21, 32'hC1, 32'h6004, 1'b0);
    step();
    idle();
    A1 = 5'd20;
    A2 = 5'd9;
    #1;
    chk("pre_reset_retire", retire_cnt, 32'd7);
    chk("pre_reset_valid", {31'd0, trc_valid}, 32'd1);
    chk("pre_reset_rd1", RD1, 32'hC0);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("async_valid", {31'd0, trc_valid}, 32'd0);
    chk("async_retire", retire_cnt, 32'd0);
    chk("async_rd1", RD1, 32'd0);
    chk("async_rd2", RD2, 32'd0);
    chk("async_trc_data", trc_data, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_reset_valid", {31'd0, trc_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/grf_wb_writer.md
Name: grf_wb_writer

Overview:
- Write-back end of the M→W pipeline interface: the general register file plus commit bookkeeping.
- Consumes the W-stage register outputs (A3_W, WD_W, PC_W, Instr_W) and commits the write into a 32x32 GPR array.
- Provides two combinational read ports to the D stage.
- Records every committed write into a small trace FIFO, drained by a valid/ready consumer, and counts retired non-bubble instructions.

Parameters:
- TRACE_DEPTH, 4, trace FIFO entries; power of two, 2..16
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- RegWrite_W  in  1  W-stage write enable
- A3_W  in  5  W-stage destination register
- WD_W  in  32  W-stage write data
- PC_W  in  32  W-stage instruction PC
- Instr_W  in  32  W-stage instruction word; 0 = bubble
- A1  in  5  read address port 1
- A2  in  5  read address port 2
- RD1  out  32  read data port 1
- RD2  out  32  read data port 2
- trc_valid  out  1  trace entry available
- trc_ready  in  1  consumer accepts entry
- trc_pc  out  32  PC of head entry
- trc_addr  out  5  register of head entry
- trc_data  out  32  data of head entry
- trc_ovf  out  1  sticky: a commit was dropped because the FIFO was full
- retire_cnt  out  CNT_W  count of retired non-bubble instructions

Behaviour:
- Reset (reset==0, asynchronous):
  - All 32 GPRs cleared to 0.
  - FIFO empty: trc_valid=0; trc_pc, trc_addr and trc_data read 0.
  - trc_ovf=0, retire_cnt=0.
  - Reset asserted mid-drain discards all entries; no partial pop.
- Commit condition: commit = RegWrite_W && (A3_W != 0).
  - On a clk rise with commit, GPR[A3_W] <= WD_W.
  - A3_W==0 never writes; GPR[0] reads 0 always.
- Reads:
  - RD1 = GPR[A1], RD2 = GPR[A2], combinational.
  - A1==0 or A2==0 yields 0 regardless of any write.
  - Same-cycle write/read behaviour is governed by the Optional Feature.
- Retire counter: increments by 1 on each clk rise where Instr_W != 0, independent of RegWrite_W. Wraps modulo 2^CNT_W.
- Trace FIFO:
  - Each commit pushes {PC_W, A3_W, WD_W} at the clk rise.
  - Pop occurs when trc_valid && trc_ready at a clk rise.
  - The head entry is presented while trc_valid=1. Outputs hold stable until popped.
  - When empty, the output data holds 0.
  - Full and no pop: the push is dropped and trc_ovf is set. trc_ovf clears only on reset.
  - Full with simultaneous pop: the push is accepted and occupancy is unchanged.
  - Empty with simultaneous push: the entry appears next cycle. No fall-through: trc_valid rises one cycle after the push.
  - Pointers are log2(TRACE_DEPTH) bits and wrap naturally. Occupancy is tracked in a separate counter of width log2(TRACE_DEPTH)+1.
- Latency:
  - Write visible on RD1/RD2 the cycle after commit (or the same cycle, see Optional Feature).
  - Trace entry visible 1 cycle after commit.

Optional Feature:
- Macro GRF_BYPASS_EN.
- Defined: when commit && A1==A3_W, RD1=WD_W in the same cycle; likewise RD2 with A2. This removes the need for W→D forwarding in the hazard unit.
- Undefined: RD1/RD2 always return stored array contents. A same-cycle write is seen only after the clk rise, and the hazard unit must forward W→D.

Test Plan:
- Reset then read: deassert reset with A1=5, A2=31 -> RD1=0, RD2=0, trc_valid=0, retire_cnt=0.
- Write/read: RegWrite_W=1, A3_W=8, WD_W=0x12345678, Instr_W nonzero, A1=8.
  - Same cycle: RD1=0x12345678 with GRF_BYPASS_EN, old value 0 without.
  - After the edge: RD1=0x12345678 in both builds.
  - retire_cnt=1.
- $zero protection: RegWrite_W=1, A3_W=0, WD_W=0xFFFFFFFF -> RD1(A1=0)=0, no trace push, trc_valid stays 0.
- Trace ordering/handshake:
  - Commit to regs 1,2,3 (data 0x11,0x22,0x33, PC 0x3000,0x3004,0x3008) with trc_ready=0 -> trc_valid=1, head shows 0x3000/1/0x11.
  - Then trc_ready=1 -> entries pop in order over 3 cycles, then trc_valid=0.
- Overflow: TRACE_DEPTH=4, trc_ready=0, 5 commits -> 5th dropped, trc_ovf=1, draining yields exactly the first 4.
  - Repeat with trc_ready=1 on the 5th cycle -> no drop, trc_ovf=0.
- Async reset mid-operation: 2 entries queued, retire_cnt=7, pull reset low between edges -> immediately trc_valid=0, retire_cnt=0, all GPR reads 0.
